relay_sequencer: RTL

RELAY_SEQUENCER -- requirements
Module: relay_sequencer

---
 rtl/relay_pkg.sv | 28 ++
 rtl/relay_timer.sv | 28 ++
 rtl/relay_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/relay_pkg.sv
// relay_pkg: shared types and constants for the latching-relay sequencer.
// Optional feature macro: RELAY_STARTUP_SWEEP_EN adds the SWEEP_NEXT state
// used by the power-on sweep of every relay to output mode.
package relay_pkg;

  localparam logic RELAY_DIR_OUT = 1'b1;
  localparam logic RELAY_DIR_IN  = 1'b0;

`ifdef RELAY_STARTUP_SWEEP_EN
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PULSE      = 2'd1,
    ST_GAP        = 2'd2,
    ST_SWEEP_NEXT = 2'd3
  } relay_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } relay_state_t;
`endif

  function automatic int relay_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relay_timer.sv
// relay_timer: loadable down-counter with terminal-count flag. Holds at zero
// instead of wrapping, so tc stays asserted until the next load.
module relay_timer #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // Load has priority; otherwise count down and saturate at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/relay_sequencer.sv
// relay_sequencer: drives NUM_RELAYS latching relays through H-bridges, one
// coil pulse at a time, each followed by a de-energized settle gap.
// Optional feature macro: RELAY_STARTUP_SWEEP_EN -- after reset, pulse every
// relay in order to output mode before accepting commands.
//
// state      | meaning
// IDLE       | waiting for a command, cmd_ready high
// PULSE      | coil of the latched relay energized for PULSE_CYCLES
// GAP        | all coils off for GAP_CYCLES, done strobes after it
// SWEEP_NEXT | (sweep build) pick the next relay of the startup sweep
module relay_sequencer
  import relay_pkg::*;
#(
  parameter int NUM_RELAYS   = 4,
  parameter int PULSE_CYCLES = 1048576,
  parameter int GAP_CYCLES   = 1048576,
  localparam int IDX_W = (NUM_RELAYS > 1) ? $clog2(NUM_RELAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [IDX_W-1:0]      cmd_index,
  input  logic                  cmd_dir,
  output logic [NUM_RELAYS-1:0] relay_a,
  output logic [NUM_RELAYS-1:0] relay_b,
  output logic [NUM_RELAYS-1:0] relay_dir,
  output logic [NUM_RELAYS-1:0] relay_known,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err
);

  localparam int CNT_W = $clog2(relay_max(PULSE_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  relay_state_t state, state_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic dir_q, dir_nxt;
  logic tmr_load, tmr_tc;
  logic [CNT_W-1:0] tmr_value;
  logic done_nxt, err_nxt;
  logic accept, in_range;
  logic [NUM_RELAYS-1:0] sel;

`ifdef RELAY_STARTUP_SWEEP_EN
  localparam int SW_W = $clog2(NUM_RELAYS + 1);
  logic [SW_W-1:0] sweep_idx, sweep_idx_nxt;
  logic sweep_on, sweep_on_nxt;
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign in_range  = (int'(cmd_index) < NUM_RELAYS);
  assign sel       = NUM_RELAYS'(1) << idx_q;

  // Only one side of one bridge is ever driven, and only during PULSE.
  assign relay_a = (state == ST_PULSE && dir_q == RELAY_DIR_IN)  ? sel : '0;
  assign relay_b = (state == ST_PULSE && dir_q == RELAY_DIR_OUT) ? sel : '0;

  relay_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tc         (tmr_tc)
  );

  // Next-state, timer loads and strobe requests.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    dir_nxt   = dir_q;
    tmr_load  = 1'b0;
    tmr_value = PULSE_LOAD;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
`ifdef RELAY_STARTUP_SWEEP_EN
    sweep_idx_nxt = sweep_idx;
    sweep_on_nxt  = sweep_on;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (in_range) begin
            idx_nxt   = cmd_index;
            dir_nxt   = cmd_dir;
            tmr_load  = 1'b1;
            state_nxt = ST_PULSE;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_PULSE: begin
        if (tmr_tc) begin
          tmr_load  = 1'b1;
          tmr_value = GAP_LOAD;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_tc) begin
          done_nxt = 1'b1;
`ifdef RELAY_STARTUP_SWEEP_EN
          state_nxt = sweep_on ? ST_SWEEP_NEXT : ST_IDLE;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef RELAY_STARTUP_SWEEP_EN
      ST_SWEEP_NEXT: begin
        if (int'(sweep_idx) < NUM_RELAYS) begin
          idx_nxt       = IDX_W'(sweep_idx);
          dir_nxt       = RELAY_DIR_OUT;
          tmr_load      = 1'b1;
          sweep_idx_nxt = sweep_idx + 1'b1;
          state_nxt     = ST_PULSE;
        end else begin
          sweep_on_nxt = 1'b0;
          state_nxt    = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, latched command, strobes and per-relay direction tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef RELAY_STARTUP_SWEEP_EN
      state <= ST_SWEEP_NEXT;
`else
      state <= ST_IDLE;
`endif
      idx_q       <= '0;
      dir_q       <= 1'b0;
      done        <= 1'b0;
      cmd_err     <= 1'b0;
      relay_dir   <= '0;
      relay_known <= '0;
    end else begin
      state   <= state_nxt;
      idx_q   <= idx_nxt;
      dir_q   <= dir_nxt;
      done    <= done_nxt;
      cmd_err <= err_nxt;
      // The relay has physically latched once its pulse completes.
      if (state == ST_PULSE && tmr_tc) begin
        relay_dir   <= (relay_dir & ~sel) | (dir_q ? sel : '0);
        relay_known <= relay_known | sel;
      end
    end
  end

`ifdef RELAY_STARTUP_SWEEP_EN
  // Startup sweep progress; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_idx <= '0;
      sweep_on  <= 1'b1;
    end else begin
      sweep_idx <= sweep_idx_nxt;
      sweep_on  <= sweep_on_nxt;
    end
  end
`endif

endmodule
